// File: rtl/sat_narrow_pkg.sv
// Shared widths, buffer state encoding and saturation bound for the narrowing paths.
package sat_narrow_pkg;
  localparam int IN_W_DEF  = 16;
  localparam int OUT_W_DEF = 8;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;

  // Largest value representable in out_w unsigned bits.
  function automatic logic [63:0] maxo(input int out_w);
    return (64'd1 << out_w) - 64'd1;
  endfunction
endpackage

// File: rtl/sat_narrow_core.sv
// Combinational unsigned narrowing with clamp-to-max and a saturation flag.
module sat_narrow_core
  import sat_narrow_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic [IN_W-1:0]  data,
  output logic [OUT_W-1:0] result,
  output logic             sat
);
  localparam logic [IN_W-1:0] MAXO = IN_W'(maxo(OUT_W));

  // Equality with MAXO fits exactly and is not saturation.
  always_comb begin
    sat    = (data > MAXO);
    result = sat ? MAXO[OUT_W-1:0] : data[OUT_W-1:0];
  end
endmodule

// File: rtl/sat_narrow_stream.sv
// Streaming narrowing converter: 2-entry output buffer plus saturation-event counter.
module sat_narrow_stream
  import sat_narrow_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CLR,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [IN_W-1:0]  IN_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [OUT_W-1:0] OUT_DATA,
  output logic             OUT_SAT,
  output logic [CNT_W-1:0] SAT_COUNT
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  buf_state_e       state, state_nxt;
  logic [OUT_W-1:0] conv_data, tail_data;
  logic             conv_sat, tail_sat;
  logic             push, pop;
  logic             load_head_in, load_head_tail, load_tail;

  sat_narrow_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
    .data   (IN_DATA),
    .result (conv_data),
    .sat    (conv_sat)
  );

  // Ready comes from registered state only, so no comb path from OUT_READY.
  assign IN_READY  = (state != TWO) & RST_N;
  assign OUT_VALID = (state != EMPTY);
  assign push      = IN_VALID & IN_READY;
  assign pop       = OUT_VALID & OUT_READY;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    load_head_in   = 1'b0;
    load_head_tail = 1'b0;
    load_tail      = 1'b0;
    case (state)
      EMPTY: if (push) begin
        state_nxt    = ONE;
        load_head_in = 1'b1;
      end
      ONE: begin
        if (push && !pop) begin
          state_nxt = TWO;
          load_tail = 1'b1;
        end else if (pop && !push) begin
          state_nxt = EMPTY;
        end else if (push && pop) begin
          load_head_in = 1'b1;
        end
      end
      TWO: if (pop) begin
        state_nxt      = ONE;
        load_head_tail = 1'b1;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Head registers drive OUT_* directly, so they hold while stalled.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OUT_DATA  <= '0;
      OUT_SAT   <= 1'b0;
      tail_data <= '0;
      tail_sat  <= 1'b0;
    end else begin
      if (load_head_in) begin
        OUT_DATA <= conv_data;
        OUT_SAT  <= conv_sat;
      end else if (load_head_tail) begin
        OUT_DATA <= tail_data;
        OUT_SAT  <= tail_sat;
      end
      if (load_tail) begin
        tail_data <= conv_data;
        tail_sat  <= conv_sat;
      end
    end
  end

  // CLR wins over the increment, but a same-cycle saturating push still counts.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      SAT_COUNT <= '0;
    end else if (CLR) begin
      SAT_COUNT <= (push && conv_sat) ? CNT_W'(1) : '0;
    end else if (push && conv_sat && (SAT_COUNT != CNT_MAX)) begin
      SAT_COUNT <= SAT_COUNT + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_sat_narrow_stream.sv
// Bench for sat_narrow_stream: directed scenarios plus randomized run against a queue model.
module tb_sat_narrow_stream;
  localparam int OUT_W   = 8;
  localparam int CNT_MAX = 65535;

  logic        CLK = 1'b0, RST_N = 1'b0, CLR = 1'b0;
  logic        IN_VALID = 1'b0, OUT_READY = 1'b0;
  logic [15:0] IN_DATA = '0;
  logic        IN_READY, OUT_VALID, OUT_SAT;
  logic [7:0]  OUT_DATA;
  logic [15:0] SAT_COUNT;

  logic        c_clr = 1'b0, c_valid = 1'b0, c_ready = 1'b1;
  logic [15:0] c_data = '0;
  logic        c_in_ready, c_out_valid, c_out_sat;
  logic [7:0]  c_out_data;
  logic [1:0]  c_cnt;

  int n_chk = 0, n_fail = 0;

  typedef struct { logic [7:0] d; logic s; } word_t;
  word_t       q[$];
  int unsigned m_cnt = 0;

  always #5 CLK = ~CLK;

  sat_narrow_stream #(.IN_W(16), .OUT_W(8), .CNT_W(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_DATA(IN_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_DATA(OUT_DATA), .OUT_SAT(OUT_SAT), .SAT_COUNT(SAT_COUNT)
  );

  sat_narrow_stream #(.IN_W(16), .OUT_W(8), .CNT_W(2)) dut_c (
    .CLK(CLK), .RST_N(RST_N), .CLR(c_clr), .IN_VALID(c_valid), .IN_READY(c_in_ready),
    .IN_DATA(c_data), .OUT_VALID(c_out_valid), .OUT_READY(c_ready),
    .OUT_DATA(c_out_data), .OUT_SAT(c_out_sat), .SAT_COUNT(c_cnt)
  );

  function automatic word_t ref_conv(input int unsigned v);
    word_t w;
    int unsigned mx;
    mx = (1 << OUT_W) - 1;
    if (v > mx) begin w.d = 8'(mx); w.s = 1'b1; end
    else        begin w.d = 8'(v % 256); w.s = 1'b0; end
    return w;
  endfunction

  // Drive one cycle on the main DUT and advance the model across the edge.
  task automatic drive_cycle(input logic v, input logic [15:0] d, input logic r, input logic c);
    bit push, pop;
    word_t w;
    IN_VALID = v; IN_DATA = d; OUT_READY = r; CLR = c;
    push = v && RST_N && (q.size() < 2);
    pop  = (q.size() > 0) && r;
    w    = ref_conv(d);
    @(posedge CLK);
    if (RST_N) begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(w);
      if (c) m_cnt = (push && w.s) ? 1 : 0;
      else if (push && w.s && m_cnt < CNT_MAX) m_cnt++;
    end
    #1;
  endtask

  task automatic test_reset;
    #2;
    n_chk++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b exp 0", OUT_VALID); end
    n_chk++; if (OUT_DATA !== 8'h00) begin n_fail++; $display("FAIL rst_out_data got %h exp 00", OUT_DATA); end
    n_chk++; if (OUT_SAT !== 1'b0) begin n_fail++; $display("FAIL rst_out_sat got %b exp 0", OUT_SAT); end
    n_chk++; if (SAT_COUNT !== 16'd0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", SAT_COUNT); end
    n_chk++; if (IN_READY !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %b exp 0", IN_READY); end
    @(posedge CLK); #2;
    RST_N = 1'b1;
    #1;
    n_chk++; if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL rel_in_ready got %b exp 1", IN_READY); end
  endtask

  task automatic test_values;
    logic [15:0] vin[4]  = '{16'h0000, 16'h00FF, 16'h0100, 16'hFFFF};
    logic [7:0]  exp_d[4] = '{8'h00, 8'hFF, 8'hFF, 8'hFF};
    logic        exp_s[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, vin[i], 1'b1, 1'b0);
      n_chk++; if (OUT_VALID !== 1'b1) begin n_fail++; $display("FAIL val_valid[%0d] got %b exp 1", i, OUT_VALID); end
      n_chk++; if (OUT_DATA !== exp_d[i]) begin n_fail++; $display("FAIL val_data[%0d] got %h exp %h", i, OUT_DATA, exp_d[i]); end
      n_chk++; if (OUT_SAT !== exp_s[i]) begin n_fail++; $display("FAIL val_sat[%0d] got %b exp %b", i, OUT_SAT, exp_s[i]); end
    end
    n_chk++; if (SAT_COUNT !== 16'd2) begin n_fail++; $display("FAIL val_count got %0d exp 2", SAT_COUNT); end
    drive_cycle(1'b0, 16'h0, 1'b1, 1'b0);
    n_chk++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL val_drain got %b exp 0", OUT_VALID); end
  endtask

  task automatic test_backpressure;
    drive_cycle(1'b1, 16'h0012, 1'b0, 1'b0);
    n_chk++; if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL bp_ready1 got %b exp 1", IN_READY); end
    drive_cycle(1'b1, 16'h0034, 1'b0, 1'b0);
    n_chk++; if (IN_READY !== 1'b0) begin n_fail++; $display("FAIL bp_ready2 got %b exp 0", IN_READY); end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 16'h0099, 1'b0, 1'b0);
      n_chk++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'h12) begin
        n_fail++; $display("FAIL bp_hold[%0d] got v=%b d=%h exp v=1 d=12", i, OUT_VALID, OUT_DATA);
      end
    end
    drive_cycle(1'b0, 16'h0, 1'b1, 1'b0);
    n_chk++; if (OUT_DATA !== 8'h34 || OUT_VALID !== 1'b1) begin
      n_fail++; $display("FAIL bp_second got v=%b d=%h exp v=1 d=34", OUT_VALID, OUT_DATA);
    end
    n_chk++; if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL bp_ready3 got %b exp 1", IN_READY); end
    drive_cycle(1'b0, 16'h0, 1'b1, 1'b0);
    n_chk++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %b exp 0", OUT_VALID); end
  endtask

  task automatic test_back_to_back;
    for (int i = 1; i <= 20; i++) begin
      drive_cycle(1'b1, 16'(i), 1'b1, 1'b0);
      n_chk++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'(i) || IN_READY !== 1'b1) begin
        n_fail++; $display("FAIL b2b[%0d] got v=%b d=%h rdy=%b exp v=1 d=%h rdy=1", i, OUT_VALID, OUT_DATA, IN_READY, 8'(i));
      end
    end
    drive_cycle(1'b0, 16'h0, 1'b1, 1'b0);
    n_chk++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b exp 0", OUT_VALID); end
  endtask

  task automatic test_counter;
    logic [1:0] exp_c[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 5; i++) begin
      c_valid = 1'b1; c_data = 16'h0200; c_clr = 1'b0;
      @(posedge CLK); #1;
      n_chk++; if (c_cnt !== exp_c[i]) begin n_fail++; $display("FAIL cnt[%0d] got %0d exp %0d", i, c_cnt, exp_c[i]); end
    end
    c_clr = 1'b1;
    @(posedge CLK); #1;
    n_chk++; if (c_cnt !== 2'd1) begin n_fail++; $display("FAIL cnt_clr_push got %0d exp 1", c_cnt); end
    c_valid = 1'b0;
    @(posedge CLK); #1;
    n_chk++; if (c_cnt !== 2'd0) begin n_fail++; $display("FAIL cnt_clr got %0d exp 0", c_cnt); end
    c_clr = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_random;
    logic [15:0] d;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      n_chk++; if (OUT_VALID !== (q.size() > 0)) begin
        n_fail++; $display("FAIL rnd_valid @%0d got %b exp %b", cyc, OUT_VALID, q.size() > 0);
      end
      if (q.size() > 0) begin
        n_chk++; if (OUT_DATA !== q[0].d || OUT_SAT !== q[0].s) begin
          n_fail++; $display("FAIL rnd_data @%0d got %h/%b exp %h/%b", cyc, OUT_DATA, OUT_SAT, q[0].d, q[0].s);
        end
      end
      n_chk++; if (IN_READY !== (q.size() < 2)) begin
        n_fail++; $display("FAIL rnd_ready @%0d got %b exp %b", cyc, IN_READY, q.size() < 2);
      end
      n_chk++; if (SAT_COUNT !== 16'(m_cnt)) begin
        n_fail++; $display("FAIL rnd_count @%0d got %0d exp %0d", cyc, SAT_COUNT, m_cnt);
      end
      d = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(250, 260)) : 16'($urandom);
      drive_cycle(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)), $urandom_range(0, 99) == 0);
    end
  endtask

  task automatic test_reset_mid;
    drive_cycle(1'b1, 16'h0300, 1'b0, 1'b0);
    drive_cycle(1'b1, 16'h0400, 1'b0, 1'b0);
    n_chk++; if (IN_READY !== 1'b0 || SAT_COUNT === 16'd0) begin
      n_fail++; $display("FAIL mid_pre got rdy=%b cnt=%0d exp rdy=0 cnt>0", IN_READY, SAT_COUNT);
    end
    IN_VALID = 1'b0;
    #2; RST_N = 1'b0; #1;
    q.delete(); m_cnt = 0;
    n_chk++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b exp 0", OUT_VALID); end
    n_chk++; if (SAT_COUNT !== 16'd0) begin n_fail++; $display("FAIL mid_count got %0d exp 0", SAT_COUNT); end
    n_chk++; if (IN_READY !== 1'b0) begin n_fail++; $display("FAIL mid_ready got %b exp 0", IN_READY); end
    @(posedge CLK); #2;
    RST_N = 1'b1; #1;
    n_chk++; if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
      n_fail++; $display("FAIL mid_release got rdy=%b v=%b exp rdy=1 v=0", IN_READY, OUT_VALID);
    end
    drive_cycle(1'b1, 16'h0055, 1'b1, 1'b0);
    n_chk++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'h55) begin
      n_fail++; $display("FAIL mid_first got v=%b d=%h exp v=1 d=55", OUT_VALID, OUT_DATA);
    end
    drive_cycle(1'b0, 16'h0, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_values();
    test_backpressure();
    test_back_to_back();
    test_counter();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
